// File: rtl/ascon_round_scheduler_pkg.sv
// Shared definitions for the ASCON permutation round scheduler.
//   sched_state_t : FSM state encoding (IDLE/LOAD/ROUND/DONE)
//   *_ROUNDS      : supported permutation round counts (p12, p6, p8)
//   round_const   : ASCON round-constant table, indexed 0..11
//   rounds_legal  : round-count legality check
package ascon_round_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_DONE
  } sched_state_t;

  localparam logic [3:0] PA_ROUNDS = 4'd12;
  localparam logic [3:0] PB_ROUNDS = 4'd6;
  localparam logic [3:0] P8_ROUNDS = 4'd8;

  // Full 12-entry table; shorter permutations start part-way in so that
  // every variant finishes on 8'h4B.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'hF0;
      4'd1:    c = 8'hE1;
      4'd2:    c = 8'hD2;
      4'd3:    c = 8'hC3;
      4'd4:    c = 8'hB4;
      4'd5:    c = 8'hA5;
      4'd6:    c = 8'h96;
      4'd7:    c = 8'h87;
      4'd8:    c = 8'h78;
      4'd9:    c = 8'h69;
      4'd10:   c = 8'h5A;
      4'd11:   c = 8'h4B;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic rounds_legal(input logic [3:0] n, input bit allow_p8);
    return (n == PA_ROUNDS) || (n == PB_ROUNDS) || (allow_p8 && (n == P8_ROUNDS));
  endfunction

endpackage

// File: rtl/ascon_round_scheduler_round_counter.sv
// ascon_round_counter: round counter for the permutation scheduler.
//   clock, reset_n : clock and synchronous active-low reset
//   latch_en       : capture num_rounds as the permutation length N
//   num_rounds     : requested round count
//   clear          : force the counter to 0
//   inc            : advance one round (wraps to 0 after the last round)
//   cnt            : current round index 0..N-1
//   last           : cnt == N-1
//   const_idx      : round-constant table index, 12-N+cnt
module ascon_round_counter
  import ascon_round_scheduler_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       latch_en,
  input  logic [3:0] num_rounds,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       last,
  output logic [3:0] const_idx
);

  logic [3:0] n_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      n_q <= PA_ROUNDS;
    end else if (latch_en) begin
      n_q <= num_rounds;
    end
  end

  // Wrapping on the last round keeps the counter within 0..11.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= last ? '0 : cnt_q + 4'd1;
    end
  end

  always_comb begin
    last      = (cnt_q == n_q - 4'd1);
    cnt       = cnt_q;
    const_idx = PA_ROUNDS - n_q + cnt_q;
  end

endmodule

// File: rtl/ascon_round_scheduler.sv
// ascon_round_scheduler: control FSM sequencing the ASCON permutation datapath.
//   clock, reset_n              : clock, synchronous active-low reset
//   i_start_valid/o_start_ready : permutation request handshake (ready in IDLE)
//   i_num_rounds                : round count, sampled on accept (12, 6, 8)
//   i_abort                     : synchronous abort back to IDLE
//   o_state_load                : datapath loads external state (LOAD)
//   o_round_en/o_round_const    : apply one round with the given constant
//   o_round_idx/o_last_round    : current round number, final-round flag
//   o_done_valid/i_done_ready   : result handshake
//   o_error                     : one-cycle pulse for a rejected round count
// All outputs are decoded from registered state; no input reaches a strobe
// combinationally.
module ascon_round_scheduler
  import ascon_round_scheduler_pkg::*;
#(
  parameter bit ALLOW_P8 = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic [3:0] i_num_rounds,
  input  logic       i_abort,
  output logic       o_state_load,
  output logic       o_round_en,
  output logic [7:0] o_round_const,
  output logic [3:0] o_round_idx,
  output logic       o_last_round,
  output logic       o_done_valid,
  input  logic       i_done_ready,
  output logic       o_error
);

  sched_state_t state_q, state_d;
  logic         accept;
  logic         legal;
  logic         err_q;
  logic [3:0]   cnt;
  logic         last;
  logic [3:0]   const_idx;

  // Abort in IDLE suppresses the accept (and therefore any error pulse).
  always_comb begin
    accept = i_start_valid && (state_q == ST_IDLE) && !i_abort;
    legal  = rounds_legal(i_num_rounds, ALLOW_P8);
  end

  ascon_round_counter u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .latch_en   (accept && legal),
    .num_rounds (i_num_rounds),
    .clear      ((state_q == ST_LOAD) || i_abort),
    .inc        (state_q == ST_ROUND),
    .cnt        (cnt),
    .last       (last),
    .const_idx  (const_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && legal) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ROUND;
      ST_ROUND: if (last) state_d = ST_DONE;
      ST_DONE:  if (i_done_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_abort) state_d = ST_IDLE;
  end

  always_comb begin
    o_start_ready = (state_q == ST_IDLE);
    o_state_load  = (state_q == ST_LOAD);
    o_round_en    = (state_q == ST_ROUND);
    o_done_valid  = (state_q == ST_DONE);
    o_error       = err_q;
    o_round_idx   = '0;
    o_round_const = '0;
    o_last_round  = 1'b0;
    if (state_q == ST_ROUND) begin
      o_round_idx   = cnt;
      o_round_const = round_const(const_idx);
      o_last_round  = last;
    end
  end

endmodule

// File: doc/ascon_round_scheduler.md
Name: ascon_round_scheduler

Overview:
- Control FSM that sequences the ASCON permutation datapath.
- Accepts a permutation request carrying a round count (p12, p8 or p6) and selects state load vs. round feedback.
- Drives the per-round constant and enable, then signals completion with a valid/ready handshake.
- Sits between the top-level mode FSM (init/AD/msg/final) and the round datapath (constant addition, substitution, diffusion).

Parameters:
- ALLOW_P8, 1, when 1 a round count of 8 is legal; when 0 only 6 and 12 are accepted.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- i_start_valid  in  1  permutation request valid.
- o_start_ready  out  1  scheduler can accept a request (high only in IDLE).
- i_num_rounds  in  4  requested rounds; sampled on accept.
- i_abort  in  1  synchronous abort; returns the FSM to IDLE.
- o_state_load  out  1  datapath state register captures the external state this cycle.
- o_round_en  out  1  datapath applies one round this cycle.
- o_round_const  out  8  round constant for the current round.
- o_round_idx  out  4  current round number, 0..N-1.
- o_last_round  out  1  high during the final round.
- o_done_valid  out  1  permutation result available in the datapath state.
- i_done_ready  in  1  consumer accepts the result.
- o_error  out  1  one-cycle pulse: illegal round count rejected.

Behaviour:
- Reset (reset_n low at a rising edge, any state):
  - FSM goes to IDLE and the round counter clears to 0.
  - Outputs: o_start_ready=1, all other outputs 0, o_round_const=8'h00.
  - Reset mid-permutation discards the operation; no done is issued.
- States: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - o_start_ready=1.
  - Accept = i_start_valid & o_start_ready.
  - On accept with a legal count (12, 6, or 8 when ALLOW_P8=1): latch N, go to LOAD.
  - On accept with an illegal count: o_error=1 the next cycle, stay in IDLE. No datapath strobes.
- LOAD:
  - One cycle, o_state_load=1.
  - Counter set to 0; next state is ROUND.
- ROUND:
  - o_round_en=1 and o_round_idx=cnt.
  - o_round_const = ASCON constant table entry [12-N+cnt], so every pN ends on constant 8'h4B.
  - o_last_round=1 when cnt==N-1.
  - cnt increments each cycle; when cnt==N-1 the next state is DONE.
  - Exactly N round cycles are issued.
- DONE:
  - o_done_valid=1 and held until i_done_ready=1.
  - The cycle after the handshake: IDLE.
  - i_done_ready is ignored outside DONE.
- Latency: request accepted at edge T.
  - LOAD during cycle T+1.
  - Rounds during cycles T+2..T+N+1.
  - o_done_valid rises in cycle T+N+2.
  - Minimum request-to-request interval is N+3 cycles.
- Outputs: all registered or decoded from the registered state; no combinational path from i_start_valid to any strobe.
- i_abort:
  - In any non-IDLE state: next state IDLE, counter cleared, no done.
  - Abort has priority over done handshake and round advance.
  - In IDLE, abort blocks accept for that cycle.
- Simultaneous i_abort and reset: reset wins; the result is identical.
- o_round_const is 8'h00 outside ROUND.
- Counter width is 4 bits; it never exceeds 11.

Decomposition:
- The shared package gains:
  - An enum typedef for the FSM states (IDLE/LOAD/ROUND/DONE).
  - Localparams for the round counts: PA_ROUNDS=12, PB_ROUNDS=6, P8_ROUNDS=8.
- The existing round-constant table in the package is the single source of constants; no local copy.
- One natural sub-module: ascon_round_counter.
  - Holds the loadable counter, last-round compare and the table index offset 12-N.
  - The FSM stays in ascon_round_scheduler.

Test Plan:
- p12: start with N=12, i_done_ready=1 -> o_state_load one cycle, then 12 o_round_en cycles with constants F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B, o_last_round only on 4B, o_done_valid in cycle T+14.
- p6 then p8 back-to-back:
  - p6 constants are 96,87,78,69,5A,4B.
  - p8 constants are B4,A5,96,87,78,69,5A,4B.
  - o_start_ready is low from T+1 until after each done handshake.
- Illegal counts:
  - N=7 -> o_error pulse of 1 cycle, no o_state_load or o_round_en, o_start_ready stays 1.
  - With ALLOW_P8=0, N=8 -> same error response.
- Backpressure: i_done_ready held low for 5 cycles in DONE -> o_done_valid is held, o_round_en=0, new i_start_valid is not accepted; the handshake then returns the FSM to IDLE the next cycle.
- Abort: i_abort at round index 3 of p12 -> next cycle IDLE, o_round_en=0, no o_done_valid; a following p6 request runs normally starting at 96.
- Reset: reset_n low for 1 cycle during round 5 -> all outputs at reset values the next cycle, o_start_ready=1, counter 0; the next request behaves as from power-up.
